mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the CPU core's two memory ports: the fetch port (fe_*) and the load/store port (mem_*).
- Arbitrates both ports onto one single-ported, variable-latency word bus (bus_*).
- Performs byte-lane steering for stores, and byte-lane extraction plus sign/zero extension for loads.
- Replaces direct core-to-RAM wiring, so the core can run against slow SRAM or an external bus.

Parameters:
- TIMEOUT_CYCLES, 255, maximum bus_ack wait before abort. Used only with the optional feature; range 1..65535.
- RESET_FE_PRIO, 0, sets last_grant at reset. 0 means the first contended grant goes to mem; 1 means it goes to fe.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fe_req  in  1  fetch request; held until fe_ack.
- fe_addr  in  32  fetch byte address; [1:0] ignored, always a word fetch.
- fe_ack  out  1  one-cycle pulse; fe_data valid in the same cycle.
- fe_data  out  32  fetched word.
- mem_req  in  1  load/store request; held with all attributes stable until mem_ack.
- mem_addr  in  32  byte address.
- mem_write  in  1  1 = store, 0 = load.
- mem_data_in  in  32  store data, right-aligned (bits [7:0] / [15:0] / [31:0]).
- mem_extend  in  1  load only: 1 = sign-extend, 0 = zero-extend.
- mem_width  in  2  0 = byte, 1 = half, 2 or 3 = word.
- mem_ack  out  1  one-cycle completion pulse.
- mem_data_out  out  32  load result, extended; 0 for stores.
- mem_misalign  out  1  pulses with mem_ack when the access was rejected as misaligned.
- bus_req  out  1  bus request; held until bus_ack.
- bus_addr  out  32  word address; [1:0] always 0.
- bus_we  out  1  bus write enable.
- bus_wstrb  out  4  byte strobes; 4'b0000 on reads.
- bus_wdata  out  32  lane-steered store data.
- bus_ack  in  1  slave completion; bus_rdata valid in the same cycle.
- bus_rdata  in  32  read word.
- bus_timeout  out  1  pulses with the aborted requester's ack. Tied to 0 without the optional feature.

Behaviour:
- Reset: all outputs 0, FSM goes to IDLE, last_grant = RESET_FE_PRIO.
- Reset mid-transaction: bus_req drops at the next edge, the in-flight transaction is abandoned, and no ack is issued. The slave must tolerate a dropped bus_req.
- FSM states: IDLE, FE_BUS, MEM_BUS, RESP.
- IDLE, neither port requesting: stay in IDLE.
- IDLE, one port requesting: grant that port.
- IDLE, both ports requesting: grant the port not in last_grant (alternating priority). Update last_grant.
- IDLE, mem granted and access misaligned (half with addr[0]=1, or word with addr[1:0]!=0): skip the bus. Go to RESP with mem_misalign=1 and data 0.
- On grant: register bus_req=1, bus_addr={addr[31:2],2'b00}, bus_we, bus_wstrb, bus_wdata. Go to FE_BUS or MEM_BUS.
- FE_BUS / MEM_BUS: all bus_* outputs held stable.
  - bus_ack=1: latch bus_rdata, drop bus_req and bus_we/bus_wstrb, go to RESP.
  - bus_ack while bus_req=0: ignored.
- RESP: one-cycle registered pulse on the granted port's ack with its data, then go to IDLE.
  - Ack-to-regrant: the earliest regrant is sampled in the IDLE cycle after RESP. A requester seeing ack may keep req high to issue back-to-back requests.
- Latency:
  - req seen in IDLE at cycle t; bus_req high at t+1.
  - Zero-wait slave (bus_ack at t+1): requester ack at t+3.
  - Throughput: one transaction per 3 cycles (IDLE, BUS, RESP) minimum.
- Store steering: bus_wdata = data replicated per lane. Byte: {4{d[7:0]}}; half: {2{d[15:0]}}; word: d.
  - wstrb byte: 4'b0001 << addr[1:0].
  - wstrb half: 4'b0011 << {addr[1],1'b0}.
  - wstrb word: 4'b1111.
- Load extraction:
  - byte = rdata >> (8*addr[1:0]), bits [7:0].
  - half = rdata >> (16*addr[1]), bits [15:0].
  - Extend to 32 bits per mem_extend.
- Request withdrawal: a requester dropping req before ack is a protocol violation, with undefined results. The arbiter uses the attributes latched at grant.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on grant and increments each cycle in FE_BUS/MEM_BUS.
  - When the count reaches TIMEOUT_CYCLES without bus_ack: drop bus_req and go to RESP. The requester's ack carries data 32'hDEADBEEF (fe) or 32'hDEADBEEF after extraction (mem load); bus_timeout=1 with that ack.
  - bus_ack arriving in the same cycle as the count hit wins; the transaction completes normally.
- Undefined: no counter exists, bus_timeout is constant 0, and the arbiter waits indefinitely.

Test Plan:
- Single fetch, fe_addr=0x100, zero-wait slave returning 0x00000013 -> bus_addr=0x100, bus_we=0, wstrb=0; fe_ack at t+3 with fe_data=0x00000013; mem_ack stays 0.
- Byte store, mem_addr=0x203, mem_width=0, mem_data_in=0x000000A5 -> bus_addr=0x200, wstrb=4'b1000, wdata=0xA5A5A5A5, bus_we=1; mem_ack pulse with mem_data_out=0.
- Signed half load, mem_addr=0x302, mem_extend=1, bus_rdata=0x8001_1234 -> mem_data_out=0xFFFF8001. Repeated with mem_extend=0 -> 0x00008001.
- fe_req and mem_req both high at reset release with RESET_FE_PRIO=0, both held through three transactions -> grant order mem, fe, mem; acks never overlap; bus_req is 0 in every IDLE and RESP cycle.
- Misaligned word load, mem_addr=0x402 -> bus_req never asserts; mem_ack and mem_misalign pulse together 2 cycles after request, with mem_data_out=0.
- Slave stalls 4 cycles, then reset is asserted in cycle 3 of the stall -> bus_req=0 and all acks 0 after the next edge; a subsequent fetch completes normally. With MEM_BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8 and a never-acking slave -> fe_ack with 0xDEADBEEF and bus_timeout=1.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Merges the core's fetch port (fe_*) and load/store port (mem_*) onto one
//   single-ported, variable-latency word bus (bus_*). Contended requests are
//   granted with alternating priority. Stores are lane-steered with byte
//   strobes. Loads are lane-extracted and sign/zero-extended. Misaligned
//   half/word accesses are rejected without touching the bus.
//
// Ports:
//   clk, reset         : clock (rising edge), synchronous active-high reset
//   fe_req/fe_addr     : fetch request (held until fe_ack), word-fetch address
//   fe_ack/fe_data     : one-cycle completion pulse with the fetched word
//   mem_req/addr/write/data_in/extend/width
//                      : load/store request, attributes stable until mem_ack
//   mem_ack/mem_data_out/mem_misalign
//                      : completion pulse, extended load data (0 for stores),
//                        misalignment flag
//   bus_req/addr/we/wstrb/wdata : bus request, held until bus_ack
//   bus_ack/bus_rdata  : slave completion with read data
//   bus_timeout        : pulses with the aborted requester's ack
//
// Optional feature:
//   Define MEM_BUS_ARBITER_TIMEOUT_EN to abort a bus transfer after
//   TIMEOUT_CYCLES cycles without bus_ack. Without it bus_timeout is tied to
//   0 and the arbiter waits indefinitely for bus_ack.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          RESET_FE_PRIO  = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fe_req,
   input  logic [31:0] fe_addr,
   output logic        fe_ack,
   output logic [31:0] fe_data,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic        mem_write,
   input  logic [31:0] mem_data_in,
   input  logic        mem_extend,
   input  logic [1:0]  mem_width,
   output logic        mem_ack,
   output logic [31:0] mem_data_out,
   output logic        mem_misalign,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_timeout
);

   typedef enum logic [1:0] {IDLE, FE_BUS, MEM_BUS, RESP} state_t;

   state_t      state_q, state_d;
   logic        grant_fe, grant_mem, bus_go;
   logic        mem_misal, in_bus, tmo_hit;
   // last_grant_mem_q = 1: mem won the last grant, so fe wins the next tie
   logic        last_grant_mem_q;
   logic        gnt_mem_p1, misal_p1, write_p1, sext_p1;
   logic [1:0]  width_p1, lane_p1;
   logic [31:0] rdata_p2;
   logic        unused_fe_lane;

   assign unused_fe_lane = ^fe_addr[1:0];

   // ---------------------------------------------------------------------------
   // Lane helpers
   // ---------------------------------------------------------------------------
   function automatic logic [3:0] store_strb(input logic [1:0] lane,
                                             input logic [1:0] width);
      logic [3:0] strb;
      case (width)
         2'd0:    strb = 4'b0001 << lane;
         2'd1:    strb = 4'b0011 << {lane[1], 1'b0};
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

   function automatic logic [31:0] store_steer(input logic [31:0] data,
                                               input logic [1:0]  width);
      logic [31:0] wd;
      case (width)
         2'd0:    wd = {4{data[7:0]}};
         2'd1:    wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  width,
                                                input logic        sext);
      logic [31:0]        b_sh, h_sh;
      logic signed [31:0] val;
      b_sh = word >> {lane, 3'b000};
      h_sh = word >> {lane[1], 4'b0000};
      case (width)
         2'd0: begin
            if (sext) val = signed'({b_sh[7:0], 24'h0}) >>> 24;
            else      val = signed'({24'h0, b_sh[7:0]});
         end
         2'd1: begin
            if (sext) val = signed'({h_sh[15:0], 16'h0}) >>> 16;
            else      val = signed'({16'h0, h_sh[15:0]});
         end
         default: val = signed'(word);
      endcase
      return unsigned'(val);
   endfunction

   // ---------------------------------------------------------------------------
   // Arbitration and next state
   // ---------------------------------------------------------------------------
   assign mem_misal = ((mem_width == 2'd1) && mem_addr[0]) ||
                      (mem_width[1] && (mem_addr[1:0] != 2'b00));
   assign in_bus    = (state_q == FE_BUS) || (state_q == MEM_BUS);

   always_comb begin
      state_d   = state_q;
      grant_fe  = 1'b0;
      grant_mem = 1'b0;
      bus_go    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fe_req && mem_req) begin
               grant_fe  = last_grant_mem_q;
               grant_mem = !last_grant_mem_q;
            end else begin
               grant_fe  = fe_req;
               grant_mem = mem_req;
            end
            bus_go = grant_fe || (grant_mem && !mem_misal);
            if (grant_fe)       state_d = FE_BUS;
            else if (grant_mem) state_d = mem_misal ? RESP : MEM_BUS;
         end
         FE_BUS, MEM_BUS: begin
            if (bus_ack || tmo_hit) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Stage p1: grant latches attributes and launches the bus request
   // Stage p2: bus completion (or abort) captures read data
   // Stage p3: registered ack pulse to the granted port
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_mem_q <= RESET_FE_PRIO;
         gnt_mem_p1       <= 1'b0;
         misal_p1         <= 1'b0;
         bus_req          <= 1'b0;
         bus_addr         <= 32'h0;
         bus_we           <= 1'b0;
         bus_wstrb        <= 4'b0000;
         bus_wdata        <= 32'h0;
         fe_ack           <= 1'b0;
         fe_data          <= 32'h0;
         mem_ack          <= 1'b0;
         mem_data_out     <= 32'h0;
         mem_misalign     <= 1'b0;
      end else begin
         fe_ack       <= 1'b0;
         mem_ack      <= 1'b0;
         mem_misalign <= 1'b0;

         if (grant_fe || grant_mem) begin
            last_grant_mem_q <= grant_mem;
            gnt_mem_p1       <= grant_mem;
            misal_p1         <= grant_mem && mem_misal;
            write_p1         <= mem_write;
            sext_p1          <= mem_extend;
            width_p1         <= mem_width;
            lane_p1          <= mem_addr[1:0];
         end

         if (bus_go) begin
            bus_req   <= 1'b1;
            bus_addr  <= grant_mem ? {mem_addr[31:2], 2'b00} : {fe_addr[31:2], 2'b00};
            bus_we    <= grant_mem && mem_write;
            bus_wstrb <= (grant_mem && mem_write) ? store_strb(mem_addr[1:0], mem_width)
                                                  : 4'b0000;
            bus_wdata <= grant_mem ? store_steer(mem_data_in, mem_width) : 32'h0;
         end

         if (in_bus && (bus_ack || tmo_hit)) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            // bus_ack wins over a coincident timeout
            rdata_p2  <= bus_ack ? bus_rdata : 32'hDEADBEEF;
         end

         if (state_q == RESP) begin
            if (gnt_mem_p1) begin
               mem_ack      <= 1'b1;
               mem_misalign <= misal_p1;
               mem_data_out <= (misal_p1 || write_p1) ? 32'h0
                               : load_extract(rdata_p2, lane_p1, width_p1, sext_p1);
            end else begin
               fe_ack  <= 1'b1;
               fe_data <= rdata_p2;
            end
         end
      end
   end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
   // Abort fires in the TIMEOUT_CYCLES-th bus cycle that sees no bus_ack.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_cnt_q;
   logic        tmo_flag_q, bus_timeout_q;

   assign tmo_hit     = in_bus && !bus_ack && (tmo_cnt_q == TMO_LAST);
   assign bus_timeout = bus_timeout_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_q     <= 16'h0;
         tmo_flag_q    <= 1'b0;
         bus_timeout_q <= 1'b0;
      end else begin
         if (grant_fe || grant_mem) begin
            tmo_cnt_q  <= 16'h0;
            tmo_flag_q <= 1'b0;
         end else if (in_bus) begin
            tmo_cnt_q  <= tmo_cnt_q + 16'd1;
         end
         if (tmo_hit) tmo_flag_q <= 1'b1;
         bus_timeout_q <= (state_q == RESP) && tmo_flag_q;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign bus_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. A behavioural slave on the bus side
// acknowledges after a programmable number of wait cycles and records the
// bus attributes it saw. Expected requester responses are queued when a
// request is driven and compared when the matching ack appears.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        fe_req;
   logic [31:0] fe_addr;
   logic        fe_ack;
   logic [31:0] fe_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic [31:0] mem_data_in;
   logic        mem_extend;
   logic [1:0]  mem_width;
   logic        mem_ack;
   logic [31:0] mem_data_out;
   logic        mem_misalign;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_timeout;

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES (TMO),
      .RESET_FE_PRIO  (1'b0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fe_req       (fe_req),
      .fe_addr      (fe_addr),
      .fe_ack       (fe_ack),
      .fe_data      (fe_data),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_write    (mem_write),
      .mem_data_in  (mem_data_in),
      .mem_extend   (mem_extend),
      .mem_width    (mem_width),
      .mem_ack      (mem_ack),
      .mem_data_out (mem_data_out),
      .mem_misalign (mem_misalign),
      .bus_req      (bus_req),
      .bus_addr     (bus_addr),
      .bus_we       (bus_we),
      .bus_wstrb    (bus_wstrb),
      .bus_wdata    (bus_wdata),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata),
      .bus_timeout  (bus_timeout)
   );

   always #5 clk = ~clk;

   // Slave: acks after slave_wait stalled cycles, captures bus attributes
   int unsigned slave_wait  = 0;
   int unsigned slave_cnt   = 0;
   logic [31:0] slave_rdata = 32'h0;
   logic [31:0] cap_addr    = 32'h0;
   logic        cap_we      = 1'b0;
   logic [3:0]  cap_wstrb   = 4'h0;
   logic [31:0] cap_wdata   = 32'h0;
   logic [31:0] addr_log[$];

   always @(negedge clk) begin
      if (bus_req) begin
         if (slave_cnt == slave_wait) begin
            bus_ack   = 1'b1;
            bus_rdata = slave_rdata;
            cap_addr  = bus_addr;
            cap_we    = bus_we;
            cap_wstrb = bus_wstrb;
            cap_wdata = bus_wdata;
            addr_log.push_back(bus_addr);
         end else begin
            bus_ack = 1'b0;
         end
         slave_cnt++;
      end else begin
         bus_ack   = 1'b0;
         slave_cnt = 0;
      end
   end

   typedef struct {
      logic        is_mem;
      logic [31:0] data;
      logic        misal;
      logic        tmo;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_bus_req",   32'(bus_req),      32'h0);
      check("rst_bus_addr",  bus_addr,          32'h0);
      check("rst_bus_we",    32'(bus_we),       32'h0);
      check("rst_bus_wstrb", 32'(bus_wstrb),    32'h0);
      check("rst_bus_wdata", bus_wdata,         32'h0);
      check("rst_acks",      32'({fe_ack, mem_ack, mem_misalign, bus_timeout}), 32'h0);
      check("rst_fe_data",   fe_data,           32'h0);
      check("rst_mem_data",  mem_data_out,      32'h0);
      reset = 1'b0;
   endtask

   // Drives one request at a negedge, waits (bounded) for its ack, compares.
   task automatic do_txn(input string tag, input logic is_mem, input logic [31:0] addr,
                         input logic wr, input logic [1:0] width, input logic ext,
                         input logic [31:0] wd, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic exp_mis,
                         input logic exp_tmo, input int exp_lat);
      exp_t        e;
      int          lat;
      logic        other, saw_req, mis, tmo;
      logic [31:0] d;
      sb.push_back('{is_mem, exp_data, exp_mis, exp_tmo, exp_lat});
      slave_rdata = rdata;
      if (is_mem) begin
         mem_addr    = addr;
         mem_write   = wr;
         mem_width   = width;
         mem_extend  = ext;
         mem_data_in = wd;
         mem_req     = 1'b1;
      end else begin
         fe_addr = addr;
         fe_req  = 1'b1;
      end
      lat = 0; other = 1'b0; saw_req = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus_req) saw_req = 1'b1;
         if (is_mem ? fe_ack : mem_ack) other = 1'b1;
         if (is_mem ? mem_ack : fe_ack) begin
            lat = i;
            break;
         end
      end
      d   = is_mem ? mem_data_out : fe_data;
      mis = mem_misalign;
      tmo = bus_timeout;
      fe_req  = 1'b0;
      mem_req = 1'b0;
      e = sb.pop_front();
      check({tag, "_latency"},   32'(lat),     32'(e.lat));
      check({tag, "_data"},      d,            e.data);
      check({tag, "_misalign"},  32'(mis),     32'(e.misal));
      check({tag, "_timeout"},   32'(tmo),     32'(e.tmo));
      check({tag, "_other_ack"}, 32'(other),   32'h0);
      check({tag, "_bus_used"},  32'(saw_req), 32'(!e.misal));
   endtask

   int          acks, last_cyc;
   logic        prev_req, stray_ack;
   exp_t        e;

   initial begin
      fe_req = 1'b0; fe_addr = 32'h0;
      mem_req = 1'b0; mem_addr = 32'h0; mem_write = 1'b0;
      mem_data_in = 32'h0; mem_extend = 1'b0; mem_width = 2'd0;
      apply_reset();

      // Single fetch, zero-wait slave
      do_txn("fetch", 1'b0, 32'h100, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000_0013,
             32'h0000_0013, 1'b0, 1'b0, 3);
      check("fetch_bus_addr", cap_addr, 32'h100);
      check("fetch_bus_we",   32'(cap_we), 32'h0);
      check("fetch_wstrb",    32'(cap_wstrb), 32'h0);

      // Byte store to lane 3
      do_txn("st_byte", 1'b1, 32'h203, 1'b1, 2'd0, 1'b0, 32'h0000_00A5, 32'h1111_1111,
             32'h0, 1'b0, 1'b0, 3);
      check("st_byte_addr",  cap_addr, 32'h200);
      check("st_byte_we",    32'(cap_we), 32'h1);
      check("st_byte_wstrb", 32'(cap_wstrb), 32'h8);
      check("st_byte_wdata", cap_wdata, 32'hA5A5_A5A5);

      // Half store to upper half
      do_txn("st_half", 1'b1, 32'h202, 1'b1, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0,
             32'h0, 1'b0, 1'b0, 3);
      check("st_half_wstrb", 32'(cap_wstrb), 32'hC);
      check("st_half_wdata", cap_wdata, 32'hBEEF_BEEF);

      // Loads with extension
      do_txn("ld_half_s", 1'b1, 32'h302, 1'b0, 2'd1, 1'b1, 32'h0, 32'h8001_1234,
             32'hFFFF_8001, 1'b0, 1'b0, 3);
      check("ld_half_s_wstrb", 32'(cap_wstrb), 32'h0);
      do_txn("ld_half_z", 1'b1, 32'h302, 1'b0, 2'd1, 1'b0, 32'h0, 32'h8001_1234,
             32'h0000_8001, 1'b0, 1'b0, 3);
      do_txn("ld_byte3_s", 1'b1, 32'h303, 1'b0, 2'd0, 1'b1, 32'h0, 32'h8001_1234,
             32'hFFFF_FF80, 1'b0, 1'b0, 3);
      do_txn("ld_byte1_s", 1'b1, 32'h301, 1'b0, 2'd0, 1'b1, 32'h0, 32'h8001_1234,
             32'h0000_0012, 1'b0, 1'b0, 3);

      // Misaligned accesses never reach the bus
      do_txn("mis_word", 1'b1, 32'h402, 1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF,
             32'h0, 1'b1, 1'b0, 2);
      do_txn("mis_half", 1'b1, 32'h301, 1'b0, 2'd1, 1'b1, 32'h0, 32'hFFFF_FFFF,
             32'h0, 1'b1, 1'b0, 2);

      // Contention from reset release: mem, fe, mem
      fe_addr = 32'h600; mem_addr = 32'h500; mem_write = 1'b0;
      mem_width = 2'd2; mem_extend = 1'b0; slave_rdata = 32'h1234_ABCD;
      addr_log.delete();
      sb.push_back('{1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 0});
      sb.push_back('{1'b0, 32'h1234_ABCD, 1'b0, 1'b0, 0});
      sb.push_back('{1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 0});
      fe_req = 1'b1; mem_req = 1'b1;
      apply_reset();
      acks = 0; last_cyc = 0; prev_req = 1'b0;
      for (int cyc = 1; cyc <= 60 && acks < 3; cyc++) begin
         @(negedge clk);
         if (fe_ack || mem_ack) begin
            e = sb.pop_front();
            check("arb_no_overlap", 32'(fe_ack && mem_ack), 32'h0);
            check("arb_port",       32'(mem_ack), 32'(e.is_mem));
            check("arb_data",       mem_ack ? mem_data_out : fe_data, e.data);
            check("arb_busreq_idle", 32'(bus_req), 32'h0);
            check("arb_busreq_resp", 32'(prev_req), 32'h0);
            if (acks > 0) check("arb_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            acks++;
            if (acks == 3) begin
               fe_req  = 1'b0;
               mem_req = 1'b0;
            end
         end
         prev_req = bus_req;
      end
      fe_req = 1'b0; mem_req = 1'b0;
      check("arb_ack_count", 32'(acks), 32'd3);
      check("arb_log_len",   32'(addr_log.size()), 32'd3);
      if (addr_log.size() == 3) begin
         check("arb_grant0", addr_log[0], 32'h500);
         check("arb_grant1", addr_log[1], 32'h600);
         check("arb_grant2", addr_log[2], 32'h500);
      end

      // Reset during a stalled bus transfer
      slave_wait = 4;
      fe_addr = 32'h700; fe_req = 1'b1;
      repeat (3) @(negedge clk);
      check("stall_bus_req", 32'(bus_req), 32'h1);
      reset = 1'b1; fe_req = 1'b0;
      @(negedge clk);
      check("rstmid_bus_req", 32'(bus_req), 32'h0);
      check("rstmid_acks",    32'({fe_ack, mem_ack}), 32'h0);
      reset = 1'b0;
      stray_ack = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (fe_ack || mem_ack || bus_req) stray_ack = 1'b1;
      end
      check("rstmid_no_ack", 32'(stray_ack), 32'h0);
      slave_wait = 0;
      do_txn("post_rst_fetch", 1'b0, 32'h104, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000_0055,
             32'h0000_0055, 1'b0, 1'b0, 3);
      check("post_rst_addr", cap_addr, 32'h104);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      // Never-acking slave: abort after TMO bus cycles
      slave_wait = 1000;
      do_txn("tmo_fetch", 1'b0, 32'h108, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0,
             32'hDEAD_BEEF, 1'b0, 1'b1, 10);
      do_txn("tmo_ld_half", 1'b1, 32'h302, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0,
             32'hFFFF_DEAD, 1'b0, 1'b1, 10);
      slave_wait = 0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
               n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
